// File: rtl/alu_multiciclo_if.sv
// ---------------------------------------------------------------------------
// alu_multiciclo_if
// Request/response bundle between the EX-stage control and the multi-cycle ALU.
//
// Signals:
//   inicio       : request strobe from the master
//   ALUcontrol   : 4-bit operation code, captured with the request
//   entradaA/B   : WIDTH-bit operands, captured with the request
//   pronto       : ALU idle and able to take a request
//   valido_saida : one-cycle pulse, ALUsaida/hi/Zero/div_zero are new
//   ALUsaida     : main result (LO for MULTU, quotient for DIVU)
//   hi           : MULTU upper half / DIVU remainder
//   Zero         : ALUsaida == 0, registered with ALUsaida
//   div_zero     : last completed DIVU had a zero divisor
//
// Handshake: a request is taken on a rising clock edge where inicio and
// pronto are both high. inicio while pronto is low is dropped, not queued.
// The response is a single-cycle valido_saida pulse; there is no
// back-pressure on the response side, so the master must consume the
// results (or rely on them being held) when the pulse is seen.
// ---------------------------------------------------------------------------
interface alu_multiciclo_if #(
    parameter int WIDTH = 32
);
    logic             inicio;
    logic [3:0]       ALUcontrol;
    logic [WIDTH-1:0] entradaA;
    logic [WIDTH-1:0] entradaB;
    logic             pronto;
    logic             valido_saida;
    logic [WIDTH-1:0] ALUsaida;
    logic [WIDTH-1:0] hi;
    logic             Zero;
    logic             div_zero;

    modport master (
        output inicio,
        output ALUcontrol,
        output entradaA,
        output entradaB,
        input  pronto,
        input  valido_saida,
        input  ALUsaida,
        input  hi,
        input  Zero,
        input  div_zero
    );

    modport slave (
        input  inicio,
        input  ALUcontrol,
        input  entradaA,
        input  entradaB,
        output pronto,
        output valido_saida,
        output ALUsaida,
        output hi,
        output Zero,
        output div_zero
    );
endinterface

// File: rtl/alu_multiciclo.sv
// ---------------------------------------------------------------------------
// alu_multiciclo
// Multi-cycle ALU for the MIPS32 EX stage. Logic/arithmetic/compare ops
// finish in one cycle; MULTU (shift-add) and DIVU (restoring) iterate one
// bit per cycle and produce a 2*WIDTH-bit result split across ALUsaida/hi.
//
// Ports:
//   clk      : clock, all state changes on the rising edge
//   reset    : synchronous, active-high reset
//   bus      : alu_multiciclo_if slave modport (request, operands, results)
//   o_estado : debug view of the FSM state (0 OCIOSO, 1 MUL, 2 DIV)
// ---------------------------------------------------------------------------
module alu_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_multiciclo_if.slave        bus,
    output logic [1:0]             o_estado
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        MUL    = 2'd1,
        DIV    = 2'd2
    } estado_t;

    // FSM
    estado_t          r_estado;
    estado_t          w_estado_next;

    // Iteration datapath. r_acc is the running HI (multiply) or partial
    // remainder (divide); r_lo is the multiplier shifting out / quotient
    // shifting in; r_op_b is the multiplicand or divisor.
    logic [CW-1:0]    r_cont;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_op_b;

    // Visible results
    logic [WIDTH-1:0] r_alusaida;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_valido;
    logic             r_div_zero;

    // Combinational helpers
    logic             w_pronto;
    logic             w_aceita;
    logic             w_ultimo;
    logic             w_b_zero;
    logic             w_is_multu;
    logic             w_is_divu;
    logic             w_div_por_zero;
    logic [WIDTH-1:0] w_res_simples;
    logic [WIDTH:0]   w_soma;
    logic [WIDTH:0]   w_tenta;
    logic             w_cabe;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH-1:0] w_div_acc;
    logic [WIDTH-1:0] w_div_lo;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_aceita       = bus.inicio && w_pronto;
    assign w_is_multu     = (bus.ALUcontrol == OP_MULTU);
    assign w_is_divu      = (bus.ALUcontrol == OP_DIVU);
    assign w_b_zero       = (bus.entradaB == '0);
    assign w_div_por_zero = w_is_divu && w_b_zero;

    // Result of every op that completes at the accept edge, including the
    // DIVU-by-zero short cut (quotient saturates to all ones).
    always_comb begin
        w_res_simples = '0;
        unique case (bus.ALUcontrol)
            OP_AND:  w_res_simples = bus.entradaA & bus.entradaB;
            OP_OR:   w_res_simples = bus.entradaA | bus.entradaB;
            OP_ADD:  w_res_simples = bus.entradaA + bus.entradaB;
            OP_SUB:  w_res_simples = bus.entradaA - bus.entradaB;
            OP_SLT:  w_res_simples = {{(WIDTH-1){1'b0}},
                                      ($signed(bus.entradaA) < $signed(bus.entradaB))};
            OP_SLTU: w_res_simples = {{(WIDTH-1){1'b0}}, (bus.entradaA < bus.entradaB)};
            OP_NOR:  w_res_simples = ~(bus.entradaA | bus.entradaB);
            OP_DIVU: w_res_simples = '1;
            default: w_res_simples = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // One shift-add step: add the multiplicand into HI when the current
    // multiplier bit is set, then shift {carry, HI, LO} right by one. The
    // bit leaving HI enters the top of LO as the multiplier bit leaves the
    // bottom, so after WIDTH steps {HI, LO} is the full product.
    // ------------------------------------------------------------------
    assign w_soma    = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_op_b} : '0);
    assign w_mul_acc = w_soma[WIDTH:1];
    assign w_mul_lo  = {w_soma[0], r_lo[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // One restoring-divide step: bring the next dividend bit into the
    // partial remainder and try to subtract the divisor. The partial
    // remainder is always below the divisor, so WIDTH+1 bits are enough
    // for the trial and its MSB is a clean borrow indicator.
    // ------------------------------------------------------------------
    assign w_tenta   = {r_acc, r_lo[WIDTH-1]} - {1'b0, r_op_b};
    assign w_cabe    = ~w_tenta[WIDTH];
    assign w_div_acc = w_cabe ? w_tenta[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_div_lo  = {r_lo[WIDTH-2:0], w_cabe};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_estado_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_estado_next = r_estado;
        unique case (r_estado)
            OCIOSO: begin
                if (w_aceita) begin
                    if (w_is_multu) begin
                        w_estado_next = MUL;
                    end else if (w_is_divu && !w_b_zero) begin
                        w_estado_next = DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (r_cont == '0) begin
                    w_estado_next = OCIOSO;
                end
            end
            default: w_estado_next = OCIOSO;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. pronto also drops while reset is high so a request
    // cannot be counted as accepted on a reset edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_pronto = (r_estado == OCIOSO) && !reset;
        w_ultimo = (r_estado != OCIOSO) && (r_cont == '0);
        o_estado = r_estado;
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cont     <= '0;
            r_acc      <= '0;
            r_lo       <= '0;
            r_op_b     <= '0;
            r_alusaida <= '0;
            r_hi       <= '0;
            r_zero     <= 1'b1;
            r_valido   <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_valido <= 1'b0;
            unique case (r_estado)
                OCIOSO: begin
                    if (w_aceita) begin
                        if (w_is_multu || (w_is_divu && !w_b_zero)) begin
                            r_acc  <= '0;
                            r_lo   <= bus.entradaA;
                            r_op_b <= bus.entradaB;
                            r_cont <= CW'(WIDTH - 1);
                        end else begin
                            r_alusaida <= w_res_simples;
                            r_zero     <= (w_res_simples == '0);
                            r_valido   <= 1'b1;
                            r_div_zero <= w_div_por_zero;
                            // hi is only touched by MULTU/DIVU; the divide
                            // by zero case reports the dividend there.
                            if (w_div_por_zero) begin
                                r_hi <= bus.entradaA;
                            end
                        end
                    end
                end
                MUL: begin
                    r_acc  <= w_mul_acc;
                    r_lo   <= w_mul_lo;
                    r_cont <= r_cont - 1'b1;
                    if (w_ultimo) begin
                        r_alusaida <= w_mul_lo;
                        r_hi       <= w_mul_acc;
                        r_zero     <= (w_mul_lo == '0);
                        r_valido   <= 1'b1;
                        r_div_zero <= 1'b0;
                    end
                end
                DIV: begin
                    r_acc  <= w_div_acc;
                    r_lo   <= w_div_lo;
                    r_cont <= r_cont - 1'b1;
                    if (w_ultimo) begin
                        r_alusaida <= w_div_lo;
                        r_hi       <= w_div_acc;
                        r_zero     <= (w_div_lo == '0);
                        r_valido   <= 1'b1;
                        r_div_zero <= 1'b0;
                    end
                end
                default: begin
                    r_valido <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Interface outputs
    // ------------------------------------------------------------------
    assign bus.pronto       = w_pronto;
    assign bus.valido_saida = r_valido;
    assign bus.ALUsaida     = r_alusaida;
    assign bus.hi           = r_hi;
    assign bus.Zero         = r_zero;
    assign bus.div_zero     = r_div_zero;

endmodule

// File: tb/tb_alu_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_alu_multiciclo
// Directed bench for alu_multiciclo at WIDTH=32 (main instance) and WIDTH=8
// (second instance for the narrow multiply case).
// ---------------------------------------------------------------------------
module tb_alu_multiciclo;

    localparam int W = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    // ------------------------------------------------------------------
    // Clock / reset / DUTs
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] estado32;
    logic [1:0] estado8;

    alu_multiciclo_if #(.WIDTH(32)) bus32 ();
    alu_multiciclo_if #(.WIDTH(8))  bus8 ();

    alu_multiciclo #(.WIDTH(32)) dut32 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus32),
        .o_estado (estado32)
    );

    alu_multiciclo #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus8),
        .o_estado (estado8)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; "cycle k" follows edge k.
    int   cyc = 0;
    logic rst_at_edge = 1'b1;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    typedef struct {
        int           due;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         upd_hi;
        logic         dz;
    } exp_t;

    exp_t         exp_q[$];
    int           busy_from  = 0;
    int           busy_until = 0;
    int           last_rst   = -1;
    logic [W-1:0] m_lo   = '0;
    logic [W-1:0] m_hi   = '0;
    logic         m_zero = 1'b1;
    logic         m_dz   = 1'b0;
    bit           checking = 1'b0;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic chk32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural result of one request accepted at edge acc_edge.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int acc_edge,
                                   output bit multi);
        exp_t           e;
        logic [2*W-1:0] p;
        e.due    = acc_edge;
        e.lo     = '0;
        e.hi     = '0;
        e.upd_hi = 1'b0;
        e.dz     = 1'b0;
        multi    = 1'b0;
        case (op)
            OP_AND:  e.lo = a & b;
            OP_OR:   e.lo = a | b;
            OP_ADD:  e.lo = a + b;
            OP_SUB:  e.lo = a - b;
            OP_SLT:  e.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: e.lo = (a < b) ? 32'd1 : 32'd0;
            OP_NOR:  e.lo = ~(a | b);
            OP_MULTU: begin
                p        = 64'(a) * 64'(b);
                e.lo     = p[W-1:0];
                e.hi     = p[2*W-1:W];
                e.upd_hi = 1'b1;
                multi    = 1'b1;
            end
            OP_DIVU: begin
                e.upd_hi = 1'b1;
                if (b == '0) begin
                    e.lo = '1;
                    e.hi = a;
                    e.dz = 1'b1;
                end else begin
                    e.lo  = a / b;
                    e.hi  = a % b;
                    multi = 1'b1;
                end
            end
            default: e.lo = '0;
        endcase
        if (multi) e.due = acc_edge + W;
        return e;
    endfunction

    function automatic bit model_pronto(input int k);
        bit busy;
        busy = (k >= busy_from) && (k < busy_until) && (busy_from > last_rst);
        return (reset === 1'b0) && !busy;
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle compare (falling edge)
    // ------------------------------------------------------------------
    always @(negedge clk) begin : compare
        logic exp_valid;
        exp_t e;
        if (checking) begin
            if (rst_at_edge) begin
                exp_q.delete();
                m_lo     = '0;
                m_hi     = '0;
                m_zero   = 1'b1;
                m_dz     = 1'b0;
                last_rst = cyc;
            end
            exp_valid = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e         = exp_q.pop_front();
                exp_valid = 1'b1;
                m_lo      = e.lo;
                if (e.upd_hi) m_hi = e.hi;
                m_zero    = (e.lo == '0);
                m_dz      = e.dz;
            end
            chk1 ("valido_saida", bus32.valido_saida, exp_valid);
            chk1 ("pronto",       bus32.pronto,       model_pronto(cyc));
            chk32("ALUsaida",     bus32.ALUsaida,     m_lo);
            chk32("hi",           bus32.hi,           m_hi);
            chk1 ("Zero",         bus32.Zero,         m_zero);
            chk1 ("div_zero",     bus32.div_zero,     m_dz);
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (called #1 after a rising edge)
    // ------------------------------------------------------------------
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        bit   multi;
        int   guard;
        guard = 0;
        while (!model_pronto(cyc) && guard < 200) begin
            bus32.inicio = 1'b0;
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_wait: model never idle (cycle %0d)", cyc);
        end
        bus32.inicio     = 1'b1;
        bus32.ALUcontrol = op;
        bus32.entradaA   = a;
        bus32.entradaB   = b;
        e = model(op, a, b, cyc + 1, multi);
        exp_q.push_back(e);
        if (multi) begin
            busy_from  = cyc + 1;
            busy_until = cyc + 1 + W;
        end
        @(posedge clk); #1;
    endtask

    // Count edges from the accept edge to the valid pulse. With hold set,
    // inicio stays high while the iteration runs and drops before the
    // block becomes idle again.
    task automatic wait_valid(input string name, input int exp_lat, input bit hold);
        int lat;
        lat = -1;
        if (!hold) bus32.inicio = 1'b0;
        for (int i = 1; i <= exp_lat + 8; i++) begin
            @(posedge clk); #1;
            if (hold && i == W - 1) bus32.inicio = 1'b0;
            if (bus32.valido_saida === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus32.inicio = 1'b0;
        chk_int(name, lat, exp_lat);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } vec_t;

    vec_t extra[$];

    initial begin
        int lat8;
        bus32.inicio = 1'b0; bus32.ALUcontrol = '0; bus32.entradaA = '0; bus32.entradaB = '0;
        bus8.inicio  = 1'b0; bus8.ALUcontrol  = '0; bus8.entradaA  = '0; bus8.entradaB  = '0;

        // Reset
        reset = 1'b1;
        @(posedge clk); #1;
        checking = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk32("reset_ALUsaida", bus32.ALUsaida, 32'h0);
        chk1 ("reset_Zero",     bus32.Zero,     1'b1);
        chk1 ("reset_pronto",   bus32.pronto,   1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk1 ("pronto_after_reset", bus32.pronto, 1'b1);

        // Back-to-back single-cycle ops
        send(OP_ADD, 32'd7, 32'd5);
        chk32("add_7_5", bus32.ALUsaida, 32'd12);
        chk1 ("b2b_pronto_1", bus32.pronto, 1'b1);
        send(OP_SUB, 32'd5, 32'd7);
        chk32("sub_5_7", bus32.ALUsaida, 32'hFFFF_FFFE);
        send(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk32("and_pattern", bus32.ALUsaida, 32'h00F0_00F0);
        chk1 ("b2b_valid", bus32.valido_saida, 1'b1);
        send(OP_NOR, 32'h0, 32'h0);
        chk32("nor_0_0", bus32.ALUsaida, 32'hFFFF_FFFF);
        chk1 ("b2b_pronto_4", bus32.pronto, 1'b1);

        // Signed vs unsigned compare
        send(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        chk32("slt_m1_1", bus32.ALUsaida, 32'd1);
        send(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        chk32("sltu_max_1", bus32.ALUsaida, 32'd0);
        send(OP_SUB, 32'd3, 32'd3);
        chk32("sub_3_3", bus32.ALUsaida, 32'd0);
        chk1 ("sub_3_3_zero", bus32.Zero, 1'b1);
        bus32.inicio = 1'b0;

        // MULTU max*max with inicio held high during the iteration
        send(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid("multu_latency", W, 1'b1);
        chk32("multu_lo", bus32.ALUsaida, 32'h0000_0001);
        chk32("multu_hi", bus32.hi,       32'hFFFF_FFFE);
        @(posedge clk); #1;
        chk1 ("multu_single_pulse", bus32.valido_saida, 1'b0);

        // DIVU 100/7
        send(OP_DIVU, 32'd100, 32'd7);
        wait_valid("divu_latency", W, 1'b0);
        chk32("divu_quo", bus32.ALUsaida, 32'd14);
        chk32("divu_rem", bus32.hi,       32'd2);
        chk1 ("divu_dz",  bus32.div_zero, 1'b0);

        // DIVU by zero, then ADD clears div_zero and leaves hi alone
        send(OP_DIVU, 32'd55, 32'd0);
        chk32("div0_quo", bus32.ALUsaida, 32'hFFFF_FFFF);
        chk32("div0_hi",  bus32.hi,       32'd55);
        chk1 ("div0_dz",  bus32.div_zero, 1'b1);
        send(OP_ADD, 32'd1, 32'd1);
        chk1 ("add_clears_dz", bus32.div_zero, 1'b0);
        chk32("add_keeps_hi",  bus32.hi,       32'd55);
        bus32.inicio = 1'b0;

        // MULTU with a zero low half
        send(OP_MULTU, 32'h8000_0000, 32'd4);
        wait_valid("multu2_latency", W, 1'b0);
        chk32("multu2_lo",   bus32.ALUsaida, 32'h0);
        chk32("multu2_hi",   bus32.hi,       32'd2);
        chk1 ("multu2_zero", bus32.Zero,     1'b1);

        // Reset in the middle of a MULTU
        send(OP_OR, 32'h0000_00A0, 32'h0000_0005);
        chk32("or_a5", bus32.ALUsaida, 32'h0000_00A5);
        send(OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
        bus32.inicio = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk1 ("abort_no_valid", bus32.valido_saida, 1'b0);
        chk32("abort_ALUsaida", bus32.ALUsaida,     32'h0);
        chk32("abort_hi",       bus32.hi,           32'h0);
        chk1 ("abort_Zero",     bus32.Zero,         1'b1);
        chk1 ("abort_pronto",   bus32.pronto,       1'b1);
        @(posedge clk); #1;

        // Further directed vectors, checked cycle by cycle
        extra.push_back('{OP_SLT,   32'd5,          32'hFFFF_FFFD});
        extra.push_back('{OP_SLT,   32'hFFFF_FFFD,  32'd5});
        extra.push_back('{4'b0101,  32'h1234_5678,  32'h1111_1111});
        extra.push_back('{OP_DIVU,  32'hFFFF_FFFF,  32'd1});
        extra.push_back('{OP_DIVU,  32'd5,          32'd9});
        extra.push_back('{OP_MULTU, 32'd0,          32'd12345});
        extra.push_back('{OP_ADD,   32'hFFFF_FFFF,  32'd1});
        extra.push_back('{OP_MULTU, 32'h1234_5678,  32'h9ABC_DEF0});
        extra.push_back('{OP_DIVU,  32'hDEAD_BEEF,  32'h0001_0000});
        foreach (extra[i]) begin
            send(extra[i].op, extra[i].a, extra[i].b);
            bus32.inicio = 1'b0;
        end
        for (int g = 0; g < 100 && exp_q.size() > 0; g++) begin
            @(posedge clk); #1;
        end
        chk_int("queue_drained", exp_q.size(), 0);

        // WIDTH=8 instance: MULTU 3*4
        chk1("w8_pronto", bus8.pronto, 1'b1);
        bus8.inicio     = 1'b1;
        bus8.ALUcontrol = OP_MULTU;
        bus8.entradaA   = 8'd3;
        bus8.entradaB   = 8'd4;
        @(posedge clk); #1;
        bus8.inicio = 1'b0;
        lat8 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus8.valido_saida === 1'b1) begin
                lat8 = i;
                break;
            end
        end
        chk_int("w8_latency", lat8, 8);
        chk32("w8_lo", {24'h0, bus8.ALUsaida}, 32'd12);
        chk32("w8_hi", {24'h0, bus8.hi},       32'd0);
        @(posedge clk); #1;
        chk1("w8_single_pulse", bus8.valido_saida, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_multiciclo.md
# alu_multiciclo

Parametrised multi-cycle ALU for the MIPS32 datapath. It keeps the single-cycle logic/arithmetic operations and adds iterative unsigned multiply and divide (HI/LO style), with a start/ready/valid handshake. The block sits in the EX stage; the control unit stalls the pipeline while `pronto` is low.

## Interface
- `WIDTH`, 32: operand/result width; legal range ≥ 4.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `inicio` in 1: request; accepted on a rising edge where `inicio && pronto`.
- `ALUcontrol` in 4: operation code, sampled at accept.
- `entradaA` in WIDTH: operand A, sampled at accept.
- `entradaB` in WIDTH: operand B, sampled at accept.
- `pronto` out 1: block can accept a request; equals (estado==OCIOSO) && !reset.
- `valido_saida` out 1: one-cycle pulse; results below are new this cycle.
- `ALUsaida` out WIDTH: main result (LO for MULTU, quotient for DIVU).
- `hi` out WIDTH: MULTU upper half / DIVU remainder; written only by those ops.
- `Zero` out 1: (ALUsaida==0), registered together with ALUsaida.
- `div_zero` out 1: last completed DIVU had B==0; cleared by any other completed op.

## Operation
- Opcodes (A,B unsigned unless noted):
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD, modulo 2^WIDTH, no overflow flag.
  - 0110 SUB, modulo 2^WIDTH.
  - 0111 SLT: signed A<B gives 1, else 0.
  - 0011 SLTU: unsigned compare.
  - 1100 NOR.
  - 1000 MULTU: {hi,ALUsaida} = A*B, 2·WIDTH bits exact.
  - 1001 DIVU: ALUsaida = A/B, hi = A%B.
  - Any other code yields result 0 and completes as a single-cycle op.
- States:
  - OCIOSO: waits for requests; `pronto`=1.
  - MUL: shift-add, one bit per cycle.
  - DIV: restoring divide, one bit per cycle.
- Transitions:
  - Single-cycle op or DIVU with B==0 accepted in OCIOSO: result registered at the accept edge; stay in OCIOSO.
  - MULTU accepted: load operands, clear accumulator, iteration counter = WIDTH-1, go to MUL.
  - DIVU with B≠0 accepted: load operands, clear accumulator, iteration counter = WIDTH-1, go to DIV.
  - MUL/DIV: perform one iteration per edge; on the edge where the counter is 0, write results and return to OCIOSO.
- DIVU with B==0: ALUsaida = all ones, hi = A, div_zero = 1, single-cycle.
- `inicio` while `pronto`=0 is ignored; it is not queued.
- Outputs hold their last completed values between operations.
- Iteration counter width is $clog2(WIDTH).

## Timing
- Reset values:
  - estado = OCIOSO.
  - ALUsaida = 0, hi = 0, Zero = 1.
  - valido_saida = 0, div_zero = 0.
  - `pronto` = 0 while `reset` is high, 1 in the first cycle after.
- Accept at edge N, single-cycle op: `valido_saida` = 1 in cycle N+1. Back-to-back accepts on consecutive edges are allowed, giving a valid pulse every cycle.
- Accept at edge N, MULTU/DIVU (B≠0):
  - `pronto` = 0 during cycles N+1 … N+WIDTH.
  - Results and `valido_saida` = 1 appear after edge N+WIDTH.
  - `pronto` returns to 1 in that same cycle; the next accept is possible at edge N+WIDTH+1.
- Reset during MUL/DIV: the operation is aborted, no `valido_saida`, and all outputs take their reset values.
- `valido_saida` is never high for two consecutive cycles for the same request.

## Test plan
- Simple ops, WIDTH=32, back-to-back:
  - Stimulus: ADD 7+5, SUB 5-7, AND F0F0_F0F0&0FF0_0FF0, NOR 0,0.
  - Required: 12; FFFF_FFFE; 00F0_00F0; FFFF_FFFF.
  - Required: one valid pulse per cycle, `pronto` constantly 1.
- SLT vs SLTU, A=FFFF_FFFF, B=1: SLT → 1, SLTU → 0. Then SUB 3-3 → 0 with Zero=1.
- MULTU FFFF_FFFF × FFFF_FFFF:
  - Required: hi=FFFF_FFFE, ALUsaida=0000_0001.
  - Required: `valido_saida` exactly 32 edges after accept.
  - `inicio` held high throughout MUL is ignored: exactly one valid pulse.
- DIVU 100/7 → ALUsaida=14, hi=2, div_zero=0, valid after 32 edges.
- DIVU 55/0 → ALUsaida=FFFF_FFFF, hi=55, div_zero=1, valid next cycle; a following ADD clears div_zero.
- Reset asserted at iteration 10 of MULTU:
  - Required: no valid pulse, ALUsaida=0, hi=0, Zero=1, `pronto` high the cycle after reset drops.
  - Repeat MULTU 3×4 at WIDTH=8: 12, valid 8 edges after accept.
